e1of2_sync_tx: RTL and testbench



---
 rtl/e1of2_sync_tx.sv | 136 +++++++++++++
 tb/tb_e1of2_sync_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/e1of2_sync_tx.sv
// e1of2_sync_tx: clocked injection port onto a four-phase return-to-zero
// dual-rail (e1of2) channel. Words from a valid/ready source are buffered in
// a small FIFO and emitted one word per handshake.
//
// Ports:
//   CLK, RESET        clock; asynchronous active-high reset (release is
//                     synchronised internally)
//   in_valid/in_ready source handshake; in_ready = FIFO not full
//   in_data  [W]      source word
//   out_t/out_f [W]   true/false rails, each driven straight from a flop
//   out_e             receiver enable, asynchronous to CLK
//   fifo_count        words currently buffered
//   sent_count [32]   completed words, present only with E1OF2_TX_STATS_EN
//
// Optional feature macro: E1OF2_TX_STATS_EN
module e1of2_sync_tx #(
  parameter int unsigned W     = 11,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SYNC  = 2
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 in_data,
  output logic [W-1:0]                 out_t,
  output logic [W-1:0]                 out_f,
  input  logic                         out_e,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
`ifdef E1OF2_TX_STATS_EN
  ,
  output logic [31:0]                  sent_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, DATA, NUL} state_t;

  logic [1:0]      rst_sync;
  logic            rst_i;
  logic [SYNC-1:0] e_sync;
  logic            e_s;
  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  state_t          state;

  // Reset asserts immediately, releases two clock edges after RESET falls.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) rst_sync <= 2'b11;
    else       rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_i = rst_sync[1];

  // out_e synchroniser; the FSM only ever looks at e_s.
  always_ff @(posedge CLK or posedge rst_i) begin
    if (rst_i) e_sync <= '0;
    else       e_sync <= {e_sync[SYNC-2:0], out_e};
  end
  assign e_s = e_sync[SYNC-1];

  assign in_ready = (fifo_count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (fifo_count != '0) && e_s;

  // Storage needs no reset: pointer reset discards the contents.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Handshake FSM; both rail vectors load or clear together on one edge.
  always_ff @(posedge CLK or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      out_t <= '0;
      out_f <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            out_t <= mem[rd_ptr];
            out_f <= ~mem[rd_ptr];
            state <= DATA;
          end
        end
        DATA: begin
          if (!e_s) begin
            out_t <= '0;
            out_f <= '0;
            state <= NUL;
          end
        end
        NUL: begin
          if (e_s) state <= IDLE;
        end
        default: begin
          out_t <= '0;
          out_f <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef E1OF2_TX_STATS_EN
  // Counts DATA->NULL transitions, wrapping at 2^32.
  always_ff @(posedge CLK or posedge rst_i) begin
    if (rst_i)                      sent_count <= '0;
    else if (state == DATA && !e_s) sent_count <= sent_count + 32'd1;
  end
`else
  // Statistics counter not built.
`endif

endmodule

// File: tb/tb_e1of2_sync_tx.sv
// tb_e1of2_sync_tx: directed self-checking bench for e1of2_sync_tx
// (W=11, DEPTH=4, SYNC=2) with a procedural receiver.
module tb_e1of2_sync_tx;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        in_valid = 1'b0;
  logic [10:0] in_data = '0;
  logic        out_e = 1'b0;
  logic        in_ready;
  logic [10:0] out_t;
  logic [10:0] out_f;
  logic [2:0]  fifo_count;
`ifdef E1OF2_TX_STATS_EN
  logic [31:0] sent_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic both_high = 1'b0;

  e1of2_sync_tx #(.W(11), .DEPTH(4), .SYNC(2)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_t      (out_t),
    .out_f      (out_f),
    .out_e      (out_e),
    .fifo_count (fifo_count)
`ifdef E1OF2_TX_STATS_EN
    ,
    .sent_count (sent_count)
`endif
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if ((out_t & out_f) != 11'd0) both_high <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [10:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin tick(1); n++; end
    chk("push_ready", 32'(in_ready), 32'd1);
    tick(1);
    in_valid = 1'b0;
  endtask

  // Wait for a word, check both rails, then run the ack/NULL phases.
  task automatic recv_word(input logic [10:0] d, input string tag);
    int n = 0;
    logic [10:0] nd;
    nd = ~d;
    while ((out_t | out_f) == 11'd0 && n < 30) begin tick(1); n++; end
    chk({tag, "_t"}, 32'(out_t), 32'(d));
    chk({tag, "_f"}, 32'(out_f), 32'(nd));
    out_e = 1'b0;
    n = 0;
    while ((out_t | out_f) != 11'd0 && n < 30) begin tick(1); n++; end
    chk({tag, "_null"}, 32'(out_t | out_f), 32'd0);
    out_e = 1'b1;
  endtask

  initial begin
    // Reset and idle state
    #2 RESET = 1'b1;
    tick(3);
    chk("rst_t", 32'(out_t), 32'd0);
    chk("rst_f", 32'(out_f), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    RESET = 1'b0;
    tick(3);

    // Word held back while out_e=0, then 3 edges after out_e rises
    push(11'h5A3);
    tick(5);
    chk("hold_rails", 32'(out_t | out_f), 32'd0);
    chk("hold_count", 32'(fifo_count), 32'd1);
    out_e = 1'b1;
    tick(2);
    chk("lat_early", 32'(out_t | out_f), 32'd0);
    tick(1);
    chk("lat_t", 32'(out_t), 32'h5A3);
    chk("lat_f", 32'(out_f), 32'h25C);
    chk("lat_count", 32'(fifo_count), 32'd0);
    recv_word(11'h5A3, "w5a3");
    tick(3);

    // Back-to-back pushes, received in order
    push(11'h001);
    push(11'h7FF);
    push(11'h400);
    recv_word(11'h001, "b0");
    recv_word(11'h7FF, "b1");
    recv_word(11'h400, "b2");
    tick(3);

    // Full FIFO blocks the next push until the first ack completes
    push(11'h123);
    tick(2);
    chk("full_first", 32'(out_t), 32'h123);
    push(11'h0AA);
    push(11'h155);
    push(11'h3C3);
    push(11'h63C);
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 11'h2F0;
    tick(5);
    chk("blocked_count", 32'(fifo_count), 32'd4);
    chk("blocked_rails", 32'(out_t), 32'h123);
    recv_word(11'h123, "f0");
    for (int n = 0; n < 30 && !in_ready; n++) tick(1);
    tick(1);
    in_valid = 1'b0;
    chk("refill_count", 32'(fifo_count), 32'd4);
    recv_word(11'h0AA, "f1");
    recv_word(11'h155, "f2");
    recv_word(11'h3C3, "f3");
    recv_word(11'h63C, "f4");
    recv_word(11'h2F0, "f5");
    tick(3);

    // Simultaneous push and pop at count 2
    out_e = 1'b0;
    tick(4);
    push(11'h0F1);
    push(11'h70E);
    chk("pp_pre", 32'(fifo_count), 32'd2);
    out_e = 1'b1;
    tick(2);
    in_valid = 1'b1;
    in_data  = 11'h222;
    tick(1);
    in_valid = 1'b0;
    chk("pp_count", 32'(fifo_count), 32'd2);
    chk("pp_rails", 32'(out_t), 32'h0F1);
    recv_word(11'h0F1, "pp0");
    recv_word(11'h70E, "pp1");
    recv_word(11'h222, "pp2");
    tick(3);

    // Reset while in DATA with another word buffered
    push(11'h5A5);
    tick(2);
    push(11'h111);
    chk("dr_rails", 32'(out_t), 32'h5A5);
    chk("dr_count", 32'(fifo_count), 32'd1);
    RESET = 1'b1;
    out_e = 1'b0;
    #1;
    chk("arst_t", 32'(out_t), 32'd0);
    chk("arst_f", 32'(out_f), 32'd0);
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    tick(2);
    RESET = 1'b0;
    tick(3);
    push(11'h6B6);
    tick(6);
    chk("post_rst_hold", 32'(out_t | out_f), 32'd0);
    chk("post_rst_count", 32'(fifo_count), 32'd1);
    out_e = 1'b1;
    recv_word(11'h6B6, "pr");
    tick(3);
    chk("post_rst_empty", 32'(fifo_count), 32'd0);

    // Five more words: six sent since the last reset
    push(11'h011);
    push(11'h022);
    push(11'h044);
    push(11'h088);
    push(11'h100);
    recv_word(11'h011, "s0");
    recv_word(11'h022, "s1");
    recv_word(11'h044, "s2");
    recv_word(11'h088, "s3");
    recv_word(11'h100, "s4");
    tick(3);
`ifdef E1OF2_TX_STATS_EN
    chk("sent_six", sent_count, 32'd6);
    RESET = 1'b1;
    #1;
    chk("sent_rst", sent_count, 32'd0);
    tick(2);
    RESET = 1'b0;
    tick(3);
`endif

    chk("no_both_high", 32'(both_high), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
